// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for a shared-resource multi-cycle MIPS datapath. A single
// memory, ALU and register file are reused across the cycles of each
// instruction. The FSM:
//   * fetches, decodes and sequences lw, sw, addi, subi, beq, bne, add and j,
//   * handshakes with memory through mem_req / mem_ready,
//   * counts retired instructions (wrapping counter),
//   * traps on an unknown opcode or on a memory wait that runs too long.
//
// Parameters
//   MEM_TIMEOUT  cycles mem_req may wait for mem_ready before trapping (1..255)
//   CNT_W        width of the retired-instruction counter
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   opcode       IR[31:26], stable from DECODE until the instruction ends
//   zero         ALU zero flag (used in BRANCH)
//   mem_ready    memory completes the current access this cycle
//   mem_req      memory access request
//   mem_we       write access, qualified by mem_req
//   iord         memory address select: 0 PC, 1 ALUOut
//   ir_write     load the instruction register
//   pc_write     load the PC
//   pc_src       PC source: 00 ALU result, 01 ALUOut, 10 jump target
//   alusrc_a     ALU A select: 0 PC, 1 reg A
//   alusrc_b     ALU B select: 00 reg B, 01 4, 10 imm, 11 imm<<2
//   aluctl       ALU operation: 2 add, 6 sub
//   reg_write    register-file write enable
//   regdst       destination register select: 1 rd, 0 rt
//   memtoreg     write-back source: 1 memory data, 0 ALUOut
//   state        current state encoding (debug)
//   illegal_op   sticky: an unknown opcode was decoded
//   mem_timeout  sticky: a memory wait exceeded MEM_TIMEOUT
//   instr_count  retired-instruction count, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alusrc_a,
    output logic [1:0]       alusrc_b,
    output logic [3:0]       aluctl,
    output logic             reg_write,
    output logic             regdst,
    output logic             memtoreg,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] OP_LW   = 6'b000011;
    localparam logic [5:0] OP_SW   = 6'b001011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SUBI = 6'b111000;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_ADD  = 6'b100010;
    localparam logic [5:0] OP_J    = 6'b010010;

    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_ALU = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    // Registered control word. The last four bits are not driven out directly;
    // they qualify the Mealy terms (mem_ready, zero) of ir_write / pc_write.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic [1:0] pc_src;
        logic       alusrc_a;
        logic [1:0] alusrc_b;
        logic [3:0] aluctl;
        logic       reg_write;
        logic       regdst;
        logic       memtoreg;
        logic       fetch;
        logic       jump;
        logic       branch;
        logic       bne;
    } ctrl_t;

    state_t     state_q;
    state_t     nxt;
    ctrl_t      ctrl_q;
    logic [7:0] wait_q;
    logic [CNT_W-1:0] count_q;
    logic       illegal_q;
    logic       timeout_q;
    logic       set_illegal;
    logic       set_timeout;
    logic       retire;
    logic       wait_expired;

    // Control word for a given state. Evaluated on the next state so the
    // outputs are registered and line up with the state they belong to.
    // opcode is stable from DECODE onward, so its value at the transition
    // edge is the instruction's opcode.
    function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req  = 1'b1;
                c.alusrc_b = 2'b01;
                c.aluctl   = ALU_ADD;
                c.fetch    = 1'b1;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                c.alusrc_b = 2'b11;
                c.aluctl   = ALU_ADD;
            end
            S_EXEC_R: begin
                c.alusrc_a = 1'b1;
                c.aluctl   = ALU_ADD;
            end
            S_EXEC_I: begin
                c.alusrc_a = 1'b1;
                c.alusrc_b = 2'b10;
                c.aluctl   = (op == OP_SUBI) ? ALU_SUB : ALU_ADD;
            end
            S_ADDR: begin
                c.alusrc_a = 1'b1;
                c.alusrc_b = 2'b10;
                c.aluctl   = ALU_ADD;
            end
            S_MEM_RD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.iord    = 1'b1;
            end
            S_WB_ALU: begin
                c.reg_write = 1'b1;
                c.regdst    = (op == OP_ADD);
            end
            S_WB_MEM: begin
                c.reg_write = 1'b1;
                c.memtoreg  = 1'b1;
            end
            S_BRANCH: begin
                c.alusrc_a = 1'b1;
                c.aluctl   = ALU_SUB;
                c.pc_src   = 2'b01;
                c.branch   = 1'b1;
                c.bne      = (op == OP_BNE);
            end
            S_JUMP: begin
                c.pc_src = 2'b10;
                c.jump   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign wait_expired = (wait_q == WAIT_LIMIT);

    // Next-state logic. A ready on the same cycle the wait limit is reached
    // wins over the timeout.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise a latch is inferred.
        nxt         = state_q;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        case (state_q)
            S_IDLE:   nxt = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    nxt = S_DECODE;
                end else if (wait_expired) begin
                    nxt         = S_TRAP;
                    set_timeout = 1'b1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_ADD:          nxt = S_EXEC_R;
                    OP_ADDI, OP_SUBI: nxt = S_EXEC_I;
                    OP_LW, OP_SW:    nxt = S_ADDR;
                    OP_BEQ, OP_BNE:  nxt = S_BRANCH;
                    OP_J:            nxt = S_JUMP;
                    default: begin
                        nxt         = S_TRAP;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: nxt = S_WB_ALU;
            S_ADDR:   nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready) begin
                    nxt = S_WB_MEM;
                end else if (wait_expired) begin
                    nxt         = S_TRAP;
                    set_timeout = 1'b1;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    nxt = S_FETCH;
                end else if (wait_expired) begin
                    nxt         = S_TRAP;
                    set_timeout = 1'b1;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: nxt = S_FETCH;
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_TRAP;
        endcase
    end

    // An instruction retires when a final state hands back to FETCH.
    assign retire = (nxt == S_FETCH) &&
                    (state_q inside {S_WB_ALU, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            wait_q    <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            state_q <= nxt;
            ctrl_q  <= decode_ctrl(nxt, opcode);

            if (nxt != state_q) begin
                wait_q <= '0;
            end else if (ctrl_q.mem_req && !mem_ready) begin
                wait_q <= wait_q + 8'd1;
            end

            if (retire) begin
                count_q <= count_q + CNT_W'(1);
            end
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign mem_req   = ctrl_q.mem_req;
    assign mem_we    = ctrl_q.mem_we;
    assign iord      = ctrl_q.iord;
    assign pc_src    = ctrl_q.pc_src;
    assign alusrc_a  = ctrl_q.alusrc_a;
    assign alusrc_b  = ctrl_q.alusrc_b;
    assign aluctl    = ctrl_q.aluctl;
    assign reg_write = ctrl_q.reg_write;
    assign regdst    = ctrl_q.regdst;
    assign memtoreg  = ctrl_q.memtoreg;

    // IR and PC load on the cycle memory returns the instruction. In BRANCH
    // the PC loads on zero (beq) or its inverse (bne); zero is the ALU result
    // of the same cycle, so it cannot be registered.
    assign ir_write = ctrl_q.fetch & mem_ready;
    assign pc_write = (ctrl_q.fetch & mem_ready) | ctrl_q.jump |
                      (ctrl_q.branch & (zero ^ ctrl_q.bne));

    assign state       = state_q;
    assign illegal_op  = illegal_q;
    assign mem_timeout = timeout_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl (MEM_TIMEOUT=3, CNT_W=4). Each scenario
// is expanded into a per-cycle list of inputs and expected observations
// (state, control word, count, sticky flags) built from the instruction's
// cycle sequence. A driver applies one entry per cycle at the falling edge,
// and a single compare process checks the DUT just after it.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int TO    = 3;
    localparam int CW    = 4;
    localparam int LIMIT = 1000;

    localparam logic [5:0] OP_LW   = 6'b000011;
    localparam logic [5:0] OP_SW   = 6'b001011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SUBI = 6'b111000;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_ADD  = 6'b100010;
    localparam logic [5:0] OP_J    = 6'b010010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    localparam int IDLE = 0, FETCH = 1, DECODE = 2, EXEC_R = 3, EXEC_I = 4,
                   ADDR = 5, MEM_RD = 6, MEM_WR = 7, WB_ALU = 8, WB_MEM = 9,
                   BRANCH = 10, JUMP = 11, TRAP = 12;

    logic          clk;
    logic          rst;
    logic [5:0]    opcode;
    logic          zero;
    logic          mem_ready;
    logic          mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0]    pc_src;
    logic          alusrc_a;
    logic [1:0]    alusrc_b;
    logic [3:0]    aluctl;
    logic          reg_write, regdst, memtoreg;
    logic [3:0]    state;
    logic          illegal_op, mem_timeout;
    logic [CW-1:0] instr_count;
    logic [16:0]   dut_ctrl;

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alusrc_a(alusrc_a),
        .alusrc_b(alusrc_b), .aluctl(aluctl), .reg_write(reg_write),
        .regdst(regdst), .memtoreg(memtoreg), .state(state),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout),
        .instr_count(instr_count)
    );

    assign dut_ctrl = {mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                       alusrc_a, alusrc_b, aluctl, reg_write, regdst, memtoreg};

    typedef struct {
        logic       rst;
        logic       rdy;
        logic       zero;
        logic [5:0] op;
        int         st;
        int         cnt;
        logic       ill;
        logic       to;
    } item_t;

    item_t q[$];
    item_t cur;
    logic  cur_valid;
    int    total;
    int    bad;
    int    m_cnt;
    logic  m_ill;
    logic  m_to;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Control word a state must present, from the state table.
    function automatic logic [16:0] exp_ctrl(input item_t it);
        logic mreq, mwe, io, irw, pcw, asa, rw, rd, mtr;
        logic [1:0] pcs, asb;
        logic [3:0] alu;
        {mreq, mwe, io, irw, pcw, asa, rw, rd, mtr} = '0;
        pcs = 2'd0; asb = 2'd0; alu = 4'd0;
        case (it.st)
            FETCH:  begin mreq = 1; asb = 2'b01; alu = 2; irw = it.rdy; pcw = it.rdy; end
            DECODE: begin asb = 2'b11; alu = 2; end
            EXEC_R: begin asa = 1; alu = 2; end
            EXEC_I: begin asa = 1; asb = 2'b10; alu = (it.op == OP_SUBI) ? 4'd6 : 4'd2; end
            ADDR:   begin asa = 1; asb = 2'b10; alu = 2; end
            MEM_RD: begin mreq = 1; io = 1; end
            MEM_WR: begin mreq = 1; mwe = 1; io = 1; end
            WB_ALU: begin rw = 1; rd = (it.op == OP_ADD); end
            WB_MEM: begin rw = 1; mtr = 1; end
            BRANCH: begin asa = 1; alu = 6; pcs = 2'b01;
                          pcw = (it.op == OP_BEQ) ? it.zero : ~it.zero; end
            JUMP:   begin pcw = 1; pcs = 2'b10; end
            default: ;
        endcase
        return {mreq, mwe, io, irw, pcw, pcs, asa, asb, alu, rw, rd, mtr};
    endfunction

    // Driver: one list entry per cycle, applied at the falling edge.
    initial begin
        cur_valid = 1'b0;
        rst       = 1'b1;
        mem_ready = 1'b0;
        zero      = 1'b0;
        opcode    = 6'd0;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                cur       = q.pop_front();
                cur_valid = 1'b1;
                rst       = cur.rst;
                mem_ready = cur.rdy;
                zero      = cur.zero;
                opcode    = cur.op;
            end else begin
                cur_valid = 1'b0;
                mem_ready = 1'b0;
            end
        end
    end

    // Compare process: every listed cycle, just after the inputs settle.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (cur_valid) begin
                check("state", 32'(state), cur.st);
                check("ctrl", 32'(dut_ctrl), 32'(exp_ctrl(cur)));
                check("instr_count", 32'(instr_count), cur.cnt);
                check("illegal_op", 32'(illegal_op), 32'(cur.ill));
                check("mem_timeout", 32'(mem_timeout), 32'(cur.to));
            end
        end
    end

    task automatic push(input logic r, input logic rdy, input int st,
                        input logic [5:0] op, input logic z);
        item_t it;
        it.rst = r; it.rdy = rdy; it.st = st; it.op = op; it.zero = z;
        it.cnt = m_cnt; it.ill = m_ill; it.to = m_to;
        q.push_back(it);
    endtask

    task automatic do_reset();
        m_cnt = 0; m_ill = 1'b0; m_to = 1'b0;
        repeat (2) push(1'b1, 1'b0, IDLE, 6'd0, 1'b0);
        push(1'b0, 1'b0, IDLE, 6'd0, 1'b0);
    endtask

    // One instruction: fd stalled FETCH cycles, md stalled memory cycles.
    task automatic instr(input logic [5:0] op, input logic z, input int fd, input int md);
        repeat (fd) push(1'b0, 1'b0, FETCH, op, z);
        push(1'b0, 1'b1, FETCH, op, z);
        push(1'b0, 1'b0, DECODE, op, z);
        case (op)
            OP_ADD: begin push(0, 0, EXEC_R, op, z); push(0, 0, WB_ALU, op, z); end
            OP_ADDI, OP_SUBI: begin push(0, 0, EXEC_I, op, z); push(0, 0, WB_ALU, op, z); end
            OP_LW: begin
                push(0, 0, ADDR, op, z);
                repeat (md) push(0, 0, MEM_RD, op, z);
                push(0, 1, MEM_RD, op, z);
                push(0, 0, WB_MEM, op, z);
            end
            OP_SW: begin
                push(0, 0, ADDR, op, z);
                repeat (md) push(0, 0, MEM_WR, op, z);
                push(0, 1, MEM_WR, op, z);
            end
            OP_BEQ, OP_BNE: push(0, 0, BRANCH, op, z);
            OP_J:           push(0, 0, JUMP, op, z);
            default: begin
                m_ill = 1'b1;
                push(0, 0, TRAP, op, z);
                return;
            end
        endcase
        m_cnt = (m_cnt + 1) % (1 << CW);
    endtask

    task automatic park();
        push(1'b0, 1'b0, FETCH, 6'd0, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() > 0 || cur_valid) && n < LIMIT) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("drain", 32'(n < LIMIT), 32'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // add with memory always ready: 1,2,3,8,1 and one retirement.
        do_reset();
        instr(OP_ADD, 1'b0, 0, 0);
        park();
        drain();
        check("lit_add_count", 32'(instr_count), 32'd1);

        // addi (one fetch stall), subi, sw (two stalls), lw (ready exactly
        // at the wait limit, so MEM_RD is held 4 cycles).
        do_reset();
        instr(OP_ADDI, 1'b0, 1, 0);
        instr(OP_SUBI, 1'b1, 0, 0);
        instr(OP_SW,   1'b0, 0, 2);
        instr(OP_LW,   1'b0, 0, 3);
        park();
        drain();
        check("lit_mix_count", 32'(instr_count), 32'd4);

        // Branches both ways and a jump.
        do_reset();
        instr(OP_BEQ, 1'b1, 0, 0);
        instr(OP_BNE, 1'b1, 0, 0);
        instr(OP_BEQ, 1'b0, 0, 0);
        instr(OP_BNE, 1'b0, 0, 0);
        instr(OP_J,   1'b0, 0, 0);
        park();
        drain();
        check("lit_br_count", 32'(instr_count), 32'd5);

        // Illegal opcode: trap, held 20 cycles even with memory ready.
        do_reset();
        instr(OP_BAD, 1'b0, 0, 0);
        repeat (20) push(1'b0, 1'b1, TRAP, OP_BAD, 1'b0);
        drain();
        check("lit_trap_state", 32'(state), 32'd12);
        check("lit_trap_flag", 32'(illegal_op), 32'd1);
        check("lit_trap_req", 32'(mem_req), 32'd0);

        // Fetch never ready: trap after 4 FETCH cycles. Reset clears the flag.
        do_reset();
        repeat (TO + 1) push(1'b0, 1'b0, FETCH, OP_J, 1'b0);
        m_to = 1'b1;
        push(1'b0, 1'b0, TRAP, OP_J, 1'b0);
        repeat (3) push(1'b0, 1'b1, TRAP, OP_J, 1'b0);
        drain();
        check("lit_to_state", 32'(state), 32'd12);
        check("lit_to_flag", 32'(mem_timeout), 32'd1);
        check("lit_to_illegal", 32'(illegal_op), 32'd0);

        // Ready arrives on the 4th FETCH cycle: decode proceeds normally.
        do_reset();
        instr(OP_J, 1'b0, TO, 0);
        park();
        drain();
        check("lit_late_fetch", 32'(instr_count), 32'd1);

        // 17 jumps wrap the 4-bit counter to 1.
        do_reset();
        repeat (17) instr(OP_J, 1'b0, 0, 0);
        park();
        drain();
        check("lit_wrap", 32'(instr_count), 32'd1);

        // Reset in the middle of a stalled store: outputs drop at once.
        do_reset();
        push(1'b0, 1'b1, FETCH, OP_SW, 1'b0);
        push(1'b0, 1'b0, DECODE, OP_SW, 1'b0);
        push(1'b0, 1'b0, ADDR, OP_SW, 1'b0);
        repeat (2) push(1'b0, 1'b0, MEM_WR, OP_SW, 1'b0);
        do_reset();
        instr(OP_ADD, 1'b0, 0, 0);
        park();
        drain();
        check("lit_after_rst", 32'(instr_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore-style FSM that sequences a shared-resource multi-cycle MIPS datapath, in which one memory, one ALU and one register file are reused across the cycles of an instruction. The block decodes the same opcode set as the single-cycle control unit, handshakes with memory and counts retired instructions. Illegal opcodes and memory timeouts send it to a trap state.

Parameters:
MEM_TIMEOUT, 15, max cycles mem_req may wait for mem_ready before trap (1..255)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26]; stable from DECODE until instruction end
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write access (valid with mem_req)
iord  out  1  0: address=PC, 1: address=ALUOut
ir_write  out  1  load IR
pc_write  out  1  load PC
pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
alusrc_a  out  1  0 PC, 1 reg A
alusrc_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
aluctl  out  4  2 add, 6 sub
reg_write, regdst, memtoreg  out  1 each  register-file controls
state  out  4  current state encoding (debug)
illegal_op  out  1  sticky; unknown opcode seen
mem_timeout  out  1  sticky; memory wait exceeded
instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Opcodes: lw 000011, sw 001011, addi 001000, subi 111000, beq 110100, bne 110101, add 100010, j 010010.
- States and encodings: IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, ADDR 5, MEM_RD 6, MEM_WR 7, WB_ALU 8, WB_MEM 9, BRANCH 10, JUMP 11, TRAP 12.
- Reset: state=IDLE, counters=0, sticky flags=0, all outputs 0. IDLE -> FETCH unconditionally on the next edge.
- FETCH: mem_req=1, iord=0, alusrc_a=0, alusrc_b=01, aluctl=2, pc_src=00. ir_write and pc_write equal mem_ready, the only Mealy terms. Stay in FETCH until mem_ready, then go to DECODE.
- DECODE: alusrc_a=0, alusrc_b=11, aluctl=2 (branch target precomputed into ALUOut). Next state: add->EXEC_R; addi/subi->EXEC_I; lw/sw->ADDR; beq/bne->BRANCH; j->JUMP; else TRAP with illegal_op set.
- EXEC_R: alusrc_a=1, alusrc_b=00, aluctl=2. Next: WB_ALU.
- EXEC_I: alusrc_a=1, alusrc_b=10, aluctl=2 for addi, 6 for subi. Next: WB_ALU.
- WB_ALU: reg_write=1, memtoreg=0, regdst=1 for add, 0 for addi/subi. Next: FETCH.
- ADDR: alusrc_a=1, alusrc_b=10, aluctl=2. Next: MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_req=1, iord=1. On mem_ready go to WB_MEM.
- MEM_WR: mem_req=1, mem_we=1, iord=1. On mem_ready go to FETCH.
- WB_MEM: reg_write=1, memtoreg=1, regdst=0. Next: FETCH.
- BRANCH: alusrc_a=1, alusrc_b=00, aluctl=6, pc_src=01. pc_write=zero for beq, ~zero for bne. Next: FETCH.
- JUMP: pc_write=1, pc_src=10. Next: FETCH.
- Every output not listed for a state is 0.
- Retire: instr_count increments by 1 on every transition into FETCH from WB_ALU, WB_MEM, MEM_WR, BRANCH or JUMP. It wraps to 0 at overflow.
- Memory wait: wait_cnt clears on every state change and increments each cycle mem_req=1 with mem_ready=0. If wait_cnt==MEM_TIMEOUT and mem_ready=0, go to TRAP and set mem_timeout. If mem_ready=1 on that same cycle, the ready wins and the FSM proceeds normally.
- TRAP: all strobes 0. The FSM holds until rst.
- Reset asserted mid-instruction: all outputs go to 0 immediately, asynchronously. No partial write completes.
- Latency with mem_ready tied high: lw 5 cycles; sw, add, addi, subi 4; beq, bne, j 3.

Test Plan:
- Reset, then mem_ready=1 and opcode=100010 -> states 1,2,3,8,1; reg_write=1 with regdst=1 in WB_ALU; instr_count=1.
- lw with mem_ready delayed 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then WB_MEM with memtoreg=1; total 8 cycles; count +1.
- beq with zero=1 -> pc_write=1, pc_src=01 in BRANCH. bne with zero=1 -> pc_write=0. Both increment count.
- opcode=111111 -> DECODE to TRAP, illegal_op=1, held for 20 cycles with mem_req=0; rst clears the flag and state returns to IDLE.
- MEM_TIMEOUT=3 with mem_ready stuck 0 in FETCH -> TRAP after 4 FETCH cycles with mem_timeout=1. A repeat run with mem_ready rising on the 4th cycle -> DECODE instead.
- CNT_W=4, 17 j instructions -> instr_count wraps to 1. rst asserted mid-MEM_WR -> mem_we drops in the same cycle.
